uart_tx_mmio: RTL
=================

Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter; the responder on the CPU data-memory bus (ce/we/addr/sel/data), so it can sit beside or in place of the data RAM in the minimal SoC.
- CPU writes bytes into a TX FIFO; a baud-rate FSM serialises them 8N1, LSB first, on txd.
- Read path is combinational with the same timing as the data RAM, so the CPU needs no stall logic.

Parameters:
- FIFO_DEPTH, 8, TX FIFO entries; must be a power of 2, minimum 2.
- DEFAULT_DIV, 16'd434, reset value of the baud divisor (clock cycles per bit).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- ce  in  1  bus chip enable; bus access is ignored when 0
- we  in  1  1 = write, 0 = read
- addr  in  32  byte address; only addr[3:2] decoded, upper bits decoded outside the block
- sel  in  4  byte lane enables; sel[0] selects data_i[7:0], sel[3] selects data_i[31:24]
- data_i  in  32  write data from CPU
- data_o  out  32  read data to CPU (combinational)
- txd  out  1  serial output; idles high
- irq_empty  out  1  high while FIFO empty and FSM idle

Behaviour:
- Register map, by addr[3:2]:
  - 0 TXDATA: write with sel[0] pushes data_i[7:0]; reads return 0.
  - 1 STATUS, read: bit0 full, bit1 fifo_empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky), bits[31:8] = level zero-extended. Write with sel[0] and data_i[3]=1 clears overflow.
  - 2 DIVISOR: bits[15:0]; write honours sel[0] and sel[1] per byte; reads return the zero-extended value.
  - 3 reserved: reads 0, writes ignored.
- data_o = 0 when ce=0 or we=1. Otherwise the addressed value, same cycle.
- Reset (async): FIFO empty, overflow=0, divisor=DEFAULT_DIV, FSM IDLE, txd=1, baud counter=0, irq_empty=1.
- Push while full is dropped and sets overflow.
- Push while full with a pop in the same cycle is accepted; level is unchanged.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally; full/empty come from the MSB compare.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on the clock edge where the FIFO is non-empty. The head byte pops into the shift register on that edge, and the divisor is latched into div_q, with 0 treated as 1.
  - A byte pushed into an empty FIFO in cycle N drives txd=0 from cycle N+2.
  - Each state lasts div_q cycles; the counter counts 0..div_q-1.
  - START: txd=0. DATA: 8 bits, LSB first, bit index 0..7. STOP: txd=1.
  - At the end of STOP: if the FIFO is non-empty, pop, re-latch the divisor and go to START with no idle gap; otherwise go to IDLE.
- A DIVISOR write mid-frame affects only the next frame.
- Frame length is exactly 10*div_q cycles.
- irq_empty is registered: fifo_empty and state==IDLE.

Decomposition:
- Shared define file: register offset constants (TX_DATA_OFF, TX_STATUS_OFF, TX_DIV_OFF), STATUS bit positions, FSM state encodings.
- One sub-module: sync_fifo (parameterised width/depth, push/pop/full/empty/level).

Test Plan:
- Reset, no bus activity -> txd=1 constantly, STATUS read = 0x0000_0002, DIVISOR read = 434, irq_empty=1.
- DIVISOR=4, write 0xA5 to TXDATA -> txd sequence per 4-cycle slot: 0,1,0,1,0,0,1,0,1,1; frame = 40 cycles; busy=1 for its duration.
- DIVISOR=2, write 3 bytes back-to-back -> 60 cycles of continuous framing, no idle high between stop and next start; irq_empty rises after the final stop bit.
- DIVISOR=100, write FIFO_DEPTH+2 bytes quickly -> one popped, FIFO fills, last push dropped, STATUS bit3=1; clear write -> bit3=0.
- Change DIVISOR from 4 to 8 mid-frame -> current frame stays 40 cycles, next frame 80 cycles.
- Reset asserted mid-DATA (async, not clock-aligned) -> txd=1 immediately, FIFO empty, STATUS = 0x0000_0002 after release.

Source files
------------

// File: rtl/uart_tx_mmio_pkg.sv
`default_nettype none
// =============================================================================
// Module      : uart_tx_mmio_pkg
// Description : Register offsets, STATUS bit positions and TX FSM encodings
//               shared by the memory-mapped UART transmitter.
// Revision    : 1.0 - initial release
// =============================================================================
package uart_tx_mmio_pkg;

    localparam logic [1:0] TX_DATA_OFF   = 2'd0;
    localparam logic [1:0] TX_STATUS_OFF = 2'd1;
    localparam logic [1:0] TX_DIV_OFF    = 2'd2;

    localparam int STAT_FULL_BIT  = 0;
    localparam int STAT_EMPTY_BIT = 1;
    localparam int STAT_BUSY_BIT  = 2;
    localparam int STAT_OVF_BIT   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // A zero divisor would never end a bit slot, so it runs as one cycle per bit.
    function automatic logic [15:0] eff_div(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_mmio_if.sv
`default_nettype none
// =============================================================================
// Module      : uart_tx_mmio_if
// Description : CPU data-memory bus (ce/we/addr/sel/data) with master/slave views.
// Revision    : 1.0 - initial release
// =============================================================================
interface uart_tx_mmio_if;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data_i;
    logic [31:0] data_o;

    modport master (output ce, we, addr, sel, data_i, input  data_o);
    modport slave  (input  ce, we, addr, sel, data_i, output data_o);
endinterface
`default_nettype wire

// File: rtl/uart_tx_mmio_sync_fifo.sv
`default_nettype none
// =============================================================================
// Module      : uart_tx_mmio_sync_fifo
// Description : Synchronous FIFO with extra-MSB pointers; a push while full is
//               accepted only when a pop happens on the same edge.
// Revision    : 1.0 - initial release
// =============================================================================
module uart_tx_mmio_sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] din,
    input  wire logic             pop,
    output logic      [WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic      [AW:0]      level
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign level     = r_wr_ptr - r_rd_ptr;
    assign dout      = r_mem[r_rd_ptr[AW-1:0]];
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end
endmodule
`default_nettype wire

// File: rtl/uart_tx_mmio.sv
`default_nettype none
// =============================================================================
// Module      : uart_tx_mmio
// Description : Memory-mapped 8N1 UART transmitter with TX FIFO, programmable
//               baud divisor and combinational RAM-timed read path.
// Revision    : 1.0 - initial release
// =============================================================================
module uart_tx_mmio
    import uart_tx_mmio_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  wire logic      clk,
    input  wire logic      rst,
    uart_tx_mmio_if.slave  bus,
    output logic           txd,
    output logic           irq_empty
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]  w_fifo_dout;
    logic        w_full, w_empty, w_pop, w_push, w_wr;
    logic [AW:0] w_level;
    logic [1:0]  w_off;
    logic [15:0] r_div;
    logic        r_ovf, r_irq;
    logic [31:0] w_status;
    logic        w_unused;

    tx_state_e   r_state, w_state_nxt;
    logic [15:0] r_cnt, w_cnt_nxt, r_div_q, w_div_q_nxt;
    logic [2:0]  r_bit, w_bit_nxt;
    logic [7:0]  r_shift, w_shift_nxt;
    logic        r_txd, w_txd_nxt, w_slot_end;

    assign w_off    = bus.addr[3:2];
    assign w_wr     = bus.ce & bus.we;
    assign w_push   = w_wr && (w_off == TX_DATA_OFF) && bus.sel[0];
    assign w_unused = ^{bus.addr[31:4], bus.addr[1:0], bus.sel[3:2], bus.data_i[31:16]};

    uart_tx_mmio_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   (bus.data_i[7:0]),
        .pop   (w_pop),
        .dout  (w_fifo_dout),
        .full  (w_full),
        .empty (w_empty),
        .level (w_level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= DEFAULT_DIV;
            r_ovf <= 1'b0;
        end else begin
            if (w_push && w_full && !w_pop)
                r_ovf <= 1'b1;
            else if (w_wr && (w_off == TX_STATUS_OFF) && bus.sel[0] && bus.data_i[STAT_OVF_BIT])
                r_ovf <= 1'b0;
            if (w_wr && (w_off == TX_DIV_OFF)) begin
                if (bus.sel[0]) r_div[7:0]  <= bus.data_i[7:0];
                if (bus.sel[1]) r_div[15:8] <= bus.data_i[15:8];
            end
        end
    end

    always_comb begin
        w_status                 = '0;
        w_status[31:8]           = 24'(w_level);
        w_status[STAT_FULL_BIT]  = w_full;
        w_status[STAT_EMPTY_BIT] = w_empty;
        w_status[STAT_BUSY_BIT]  = (r_state != ST_IDLE);
        w_status[STAT_OVF_BIT]   = r_ovf;
    end

    always_comb begin
        bus.data_o = '0;
        if (bus.ce && !bus.we) begin
            case (w_off)
                TX_STATUS_OFF: bus.data_o = w_status;
                TX_DIV_OFF:    bus.data_o = {16'd0, r_div};
                default:       bus.data_o = '0;
            endcase
        end
    end

    assign w_slot_end = (r_cnt == r_div_q - 16'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_div_q <= 16'd1;
            r_txd   <= 1'b1;
            r_irq   <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_div_q <= w_div_q_nxt;
            r_txd   <= w_txd_nxt;
            r_irq   <= w_empty && (r_state == ST_IDLE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_div_q_nxt = r_div_q;
        w_txd_nxt   = r_txd;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) w_pop = 1'b1;
            end
            ST_START: begin
                if (w_slot_end) begin
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = ST_DATA;
                    w_txd_nxt   = r_shift[0];
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            ST_DATA: begin
                if (w_slot_end) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = r_shift >> 1;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = ST_STOP;
                        w_txd_nxt   = 1'b1;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                        w_txd_nxt = r_shift[1];
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            ST_STOP: begin
                if (w_slot_end) begin
                    w_cnt_nxt = '0;
                    if (!w_empty) w_pop = 1'b1;
                    else          w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // Every frame start (from IDLE or back-to-back after STOP) loads here.
        if (w_pop) begin
            w_state_nxt = ST_START;
            w_cnt_nxt   = '0;
            w_shift_nxt = w_fifo_dout;
            w_div_q_nxt = eff_div(r_div);
            w_txd_nxt   = 1'b0;
        end
    end

    assign txd       = r_txd;
    assign irq_empty = r_irq;
endmodule
`default_nettype wire
